// File: rtl/ram_dp_sync_if.sv
// ram_dp_sync_if
//  Bus bundle for ram_dp_sync: port A (read/write, byte enables), port B
//  (read only) and the busy flag. clk/reset are not part of the bundle.
//  Optional: RAM_PARITY_EN adds the a_perr/b_perr parity-error flags.
// Modports
//  master  drives requests (a_*, b_* inputs), observes dout/busy/perr
//  slave   the RAM itself
interface ram_dp_sync_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                      a_cen;
    logic                      a_wen;
    logic [DATA_WIDTH/8-1:0]   a_be;
    logic [ADDR_WIDTH-1:0]     a_addr;
    logic [DATA_WIDTH-1:0]     a_din;
    logic [DATA_WIDTH-1:0]     a_dout;
    logic                      b_cen;
    logic [ADDR_WIDTH-1:0]     b_addr;
    logic [DATA_WIDTH-1:0]     b_dout;
    logic                      busy;
`ifdef RAM_PARITY_EN
    logic                      a_perr;
    logic                      b_perr;
`endif

    modport master (
        output a_cen, a_wen, a_be, a_addr, a_din, b_cen, b_addr,
        input  a_dout, b_dout,
`ifdef RAM_PARITY_EN
        input  a_perr, b_perr,
`endif
        input  busy
    );

    modport slave (
        input  a_cen, a_wen, a_be, a_addr, a_din, b_cen, b_addr,
        output a_dout, b_dout,
`ifdef RAM_PARITY_EN
        output a_perr, b_perr,
`endif
        output busy
    );
endinterface

// File: rtl/ram_dp_sync.sv
// ram_dp_sync
//  Synchronous dual-port RAM. Port A reads/writes with byte enables, port B
//  reads only. After reset a clear sweep writes zero to every word, one word
//  per cycle; busy is high during the sweep and all requests are ignored.
//  Optional macro RAM_PARITY_EN: one even-parity bit per byte lane, checked on
//  reads and reported on a_perr/b_perr alongside the data.
// Ports
//  clk    rising-edge clock
//  reset  synchronous, active-high
//  bus    ram_dp_sync_if.slave (a_*, b_*, busy, optional a_perr/b_perr)
//
//  state | meaning
//  CLEAR | sweeping zeros through memory, one word per cycle; busy = 1
//  READY | normal port A / port B service
module ram_dp_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic           clk,
    input  logic           reset,
    ram_dp_sync_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    clr_we, a_we, a_rd, b_rd, idle_out;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   a_dout_q, b_dout_q;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        else       state <= state_nx;
    end

    // next state
    always_comb begin
        state_nx = state;
        if (state == CLEAR && ptr == '1) state_nx = READY;
    end

    // control outputs; requests during reset are dropped so reset never
    // touches memory contents
    always_comb begin
        clr_we   = 1'b0;
        a_we     = 1'b0;
        a_rd     = 1'b0;
        b_rd     = 1'b0;
        idle_out = 1'b1;
        if (!reset) begin
            if (state == CLEAR) begin
                clr_we = 1'b1;
            end else begin
                idle_out = 1'b0;
                a_we     = bus.a_cen &  bus.a_wen;
                a_rd     = bus.a_cen & ~bus.a_wen;
                b_rd     = bus.b_cen;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       ptr <= '0;
        else if (clr_we) ptr <= ptr + 1'b1;
    end

    assign bus.busy = (state == CLEAR);

    // memory array: no reset, read-first on collisions by virtue of <=
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr] <= '0;
        end else if (a_we) begin
            for (int i = 0; i < NB; i++)
                if (bus.a_be[i]) mem[bus.a_addr][8*i +: 8] <= bus.a_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || idle_out) begin
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            a_dout_q <= a_rd ? mem[bus.a_addr] : '0;
            b_dout_q <= b_rd ? mem[bus.b_addr] : '0;
        end
    end

    assign bus.a_dout = a_dout_q;
    assign bus.b_dout = b_dout_q;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] mem_par [DEPTH];
    logic          a_perr_q, b_perr_q;

    function automatic logic [NB-1:0] lane_par(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        p = '0;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_par[ptr] <= '0;
        end else if (a_we) begin
            for (int i = 0; i < NB; i++)
                if (bus.a_be[i]) mem_par[bus.a_addr][i] <= ^bus.a_din[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || idle_out) begin
            a_perr_q <= 1'b0;
            b_perr_q <= 1'b0;
        end else begin
            a_perr_q <= a_rd && (lane_par(mem[bus.a_addr]) != mem_par[bus.a_addr]);
            b_perr_q <= b_rd && (lane_par(mem[bus.b_addr]) != mem_par[bus.b_addr]);
        end
    end

    assign bus.a_perr = a_perr_q;
    assign bus.b_perr = b_perr_q;
`endif
endmodule
